// File: rtl/cla_addsub_serial.sv
// ============================================================================
// cla_addsub_serial
// ----------------------------------------------------------------------------
// Nibble-serial adder/subtractor. One 4-bit carry-lookahead slice is reused
// over NIB clock cycles, least significant nibble first. A running carry
// register links consecutive nibbles. Subtraction is done as
// A + ~B + ~borrow_in, and the final carry is inverted to report a borrow.
//
// Ports
//   clk    in   1     single clock, rising edge
//   rst    in   1     synchronous active-high reset
//   start  in   1     begin an operation (accepted in IDLE or DONE only)
//   sub    in   1     0 = add, 1 = subtract
//   a      in   W     operand A
//   b      in   W     operand B
//   cin    in   1     carry-in (add) / borrow-in (subtract)
//   s      out  W     registered result, updated when DONE is entered
//   cout   out  1     carry-out (add) / borrow-out (subtract)
//   ovf    out  1     two's-complement signed overflow
//   busy   out  1     high while nibbles are being processed (RUN)
//   done   out  1     one-cycle pulse, result valid (DONE)
//
// Timing (NIB = 4): start sampled at edge E0, nibbles 0..3 processed at
// E1..E4, DONE entered at E4, done high for the cycle after E4.
// ============================================================================
module cla_addsub_serial #(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    // Width of the nibble index; at least one bit even when NIB = 1.
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q,     k_d;
    logic [W-1:0]    a_q,     a_d;      // latched operand A
    logic [W-1:0]    b_q,     b_d;      // latched B' (already inverted for sub)
    logic            carry_q, carry_d;  // running carry between nibbles
    logic            sub_q,   sub_d;    // operation mode of the current op
    logic [W-1:0]    acc_q,   acc_d;    // partial sum nibbles
    logic [W-1:0]    s_q,     s_d;
    logic            cout_q,  cout_d;
    logic            ovf_q,   ovf_d;

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead slice on nibble k
    // ------------------------------------------------------------------
    logic [KW+1:0] nib_base;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    g;
    logic [3:0]    p;
    logic [4:0]    c;
    logic [3:0]    sum_nib;
    logic          last_nib;

    assign nib_base = {k_q, 2'b00};
    assign a_nib    = a_q[nib_base +: 4];
    assign b_nib    = b_q[nib_base +: 4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = a_nib[gi] & b_nib[gi];
            assign p[gi] = a_nib[gi] ^ b_nib[gi];
        end
    endgenerate

    // Every carry is a flat sum-of-products of g, p and the incoming carry,
    // so no carry depends on another carry inside the slice.
    assign c[0] = carry_q;
    assign c[1] = g[0]
                | (p[0] & c[0]);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_nib  = p ^ c[3:0];
    assign last_nib = (k_q == K_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    sub_d   = sub;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                acc_d[nib_base +: 4] = sum_nib;
                carry_d              = c[4];
                if (last_nib) begin
                    k_d     = '0;
                    state_d = DONE;
                    // Result registers take the completed sum, including the
                    // nibble being produced in this very cycle.
                    s_d              = acc_q;
                    s_d[nib_base +: 4] = sum_nib;
                    cout_d           = sub_q ? ~c[4] : c[4];
                    // In the top nibble, c[3] is the carry into the MSB and
                    // c[4] the carry out of it.
                    ovf_d            = c[3] ^ c[4];
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_cla_addsub_serial.sv
module tb_cla_addsub_serial;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];

    cla_addsub_serial #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected stopped");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_s", {16'd0, s}, {16'd0, e.s});
                check("result_cout", {31'd0, cout}, {31'd0, e.c});
                check("result_ovf", {31'd0, ovf}, {31'd0, e.o});
                $display("result s=0x%04h cout=%0b ovf=%0b (exp s=0x%04h cout=%0b ovf=%0b)",
                         s, cout, ovf, e.s, e.c, e.o);
            end
        end
    end

    // Waits (bounded) for done; returns the number of negedges taken.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int nbusy;
        exp_t e;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; latched operands must not change.
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = ~tcin; sub = ~tsub;
        nbusy = 0;
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            if (busy && !done) nbusy++;
        end
        check({name, "_busy_cycles"}, nbusy, NIB);
        @(negedge clk);
        check({name, "_done_latency"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        exp_t e;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_s", {16'd0, s}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors: name, a, b, cin, sub, expected s, cout, ovf
        run_op("add_basic",   16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("add_chain",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_nib",     16'h000D, 16'h000B, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
        run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("add_cin",     16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        run_op("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_op("sub_bin",     16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0);
        run_op("sub_zero",    16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

        // start pulsed during RUN must be ignored
        @(posedge clk); #1;
        a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; start = 1'b1;
        e.s = 16'h0007; e.c = 1'b0; e.o = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("run_start_latency", n, 3);
        @(negedge clk);
        check("run_start_no_restart", {30'd0, busy, done}, 32'd0);

        // start held through DONE: back-to-back with no IDLE cycle
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        e.s = 16'h3333; e.c = 1'b0; e.o = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h1111; cin = 1'b0; sub = 1'b1;
        e.s = 16'h2222; e.c = 1'b0; e.o = 1'b0;
        exp_q.push_back(e);
        wait_done(n);
        check("b2b_first_latency", n, NIB + 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b_second_latency", n, NIB);
        @(negedge clk);

        // reset during the second RUN cycle aborts the operation
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_s", {16'd0, s}, 32'd0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n, 0);

        // start in the same cycle as rst is ignored
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", {31'd0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_addsub_serial.md
CLA_ADDSUB_SERIAL -- requirements
Module: cla_addsub_serial

Interface
REQ-001 SHALL have parameter NIB, default 4: number of 4-bit nibbles per operand. Operand width W = 4*NIB; the default W is 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-006 SHALL have port a, input, W bits: operand A.
REQ-007 SHALL have port b, input, W bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in when adding, borrow-in when subtracting.
REQ-009 SHALL have port s, output, W bits: registered result.
REQ-010 SHALL have port cout, output, 1 bit: carry-out when adding, borrow-out when subtracting.
REQ-011 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-012 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept start only in IDLE or DONE; on acceptance SHALL:
- latch A = a and B' = sub ? ~b : b;
- latch C0 = sub ? ~cin : cin;
- load nibble index k = 0 and enter RUN.
REQ-016 SHALL ignore start while in RUN; the latched operands SHALL be unaffected by input changes after acceptance.
REQ-017 In RUN, each cycle SHALL process nibble k, LSB first, using 4-bit carry-lookahead:
- g = A&B', p = A^B';
- c1..c4 computed as explicit lookahead sum-of-products from g, p and the running carry (no ripple chain);
- sum nibble = p ^ {c3,c2,c1,c0}.
REQ-018 SHALL hold the running carry in a register between nibbles: c4 of nibble k becomes c0 of nibble k+1.
REQ-019 SHALL leave RUN after NIB cycles and enter DONE. With NIB=4: start sampled at edge E0, nibbles processed at E1..E4, DONE entered at E4, done high for the cycle following E4.
REQ-020 SHALL update s, cout and ovf only on the edge entering DONE, and hold them until the next completion.
REQ-021 SHALL drive cout = final carry when sub=0 and cout = ~final carry (borrow) when sub=1.
REQ-022 SHALL drive ovf = (carry into MSB) XOR (carry out of MSB) for both add and subtract.
REQ-023 SHALL drive busy = 1 exactly in RUN and done = 1 exactly in DONE; both are never high together.
REQ-024 SHALL go DONE -> IDLE after one cycle, or DONE -> RUN if start is high in DONE, giving back-to-back operation with one DONE cycle between results.
REQ-025 SHALL compute results modulo 2^W, with no saturation.

Reset
REQ-026 While rst is high at a clock edge, SHALL enter IDLE and clear to 0: s, cout, ovf, busy, done, k, the running carry and the latched operands.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation: no done pulse, and s keeps the reset value 0.
REQ-028 start sampled in the same cycle as rst SHALL be ignored.

Verification
REQ-029 Add: a=0x1234, b=0x0FCD, cin=0, sub=0 -> s=0x2201, cout=0, ovf=0; busy high for 4 cycles, done 1 cycle after.
REQ-030 Carry chain across all nibbles: a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0. Also a=0x000D, b=0x000B -> s=0x0018, cout=0.
REQ-031 Signed overflow on add: a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1.
REQ-032 Subtract:
- a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout(borrow)=1, ovf=0;
- a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=0, ovf=1;
- a=0x0010, b=0x0001, cin=1, sub=1 -> s=0x000E.
REQ-033 Handshake:
- start pulsed again during RUN -> ignored, and the first result completes unchanged;
- start held high through DONE -> second operation begins with no IDLE cycle.
REQ-034 Reset mid-operation: rst at the 2nd RUN cycle -> next cycle busy=0, done=0, s=0, and no done pulse follows.
